// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose
//   Multi-cycle wide adder. A W = 4*NIBBLES bit operand pair is pushed through
//   a single external 4-bit ripple adder, one nibble per clock, starting with
//   the least-significant nibble. The carry-out of each nibble is registered
//   and used as the carry-in of the next one. Only one transaction is in
//   flight at a time.
//
// Handshake
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. The sender holds valid and its data until that edge. This block
//   holds out_valid, out_sum, out_cout (and out_ovf) stable until out_ready
//   is seen. in_ready is low from the accept edge until the result has been
//   taken, so the block never accepts a new pair in the same cycle that it
//   hands off a result.
//
// Parameters
//   NIBBLES   operand width in nibbles, 1..16 (W = 4*NIBBLES)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_cin    operands and carry-in to nibble 0
//   add_a, add_b, add_cin drive the external 4-bit adder (0 outside RUN)
//   add_sum, add_cout     combinational result of the external adder
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     A+B+cin modulo 2^W and carry out of bit W-1
//   out_ovf               signed overflow flag (OVERFLOW_FLAG_EN builds only)
//
// Configuration
//   OVERFLOW_FLAG_EN  when defined, adds the out_ovf output.
// ---------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                 out_ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  // idx is at least one bit wide so NIBBLES=1 still has a legal counter.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            carry;
  logic [IW-1:0]   idx;

  logic            accept;
  logic            last_nibble;
  // Bit offset of the nibble currently being added ({idx,2'b00} == 4*idx).
  logic [IW+1:0]   bit_ofs;

  assign accept      = (state == IDLE) && in_valid;
  assign last_nibble = (idx == LAST_IDX);
  assign bit_ofs     = {idx, 2'b00};

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // External adder drive: only meaningful in RUN, quiet otherwise so the
  // adder inputs do not toggle while idle or waiting on the consumer.
  // -------------------------------------------------------------------------
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[bit_ofs +: 4];
      add_b   = b_reg[bit_ofs +: 4];
      add_cin = carry;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: operand capture, nibble-by-nibble result capture, carry chain.
  // idx parks on the last nibble after RUN and is cleared on the next accept,
  // so it never runs past NIBBLES-1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry <= in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_reg[bit_ofs +: 4] <= add_sum;
      carry                 <= add_cout;
      if (!last_nibble) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result outputs. Gated by out_valid so partially built sums seen during
  // RUN never leak out, and outputs read as zero outside DONE.
  // -------------------------------------------------------------------------
  assign out_sum  = out_valid ? sum_reg : '0;
  assign out_cout = out_valid ? carry : 1'b0;

`ifdef OVERFLOW_FLAG_EN
  // Signed overflow: operands share a sign and the result sign differs.
  assign out_ovf = out_valid &&
                   (a_reg[W-1] == b_reg[W-1]) &&
                   (sum_reg[W-1] != a_reg[W-1]);
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder. u_dut uses NIBBLES=4; u_dut1 uses
// NIBBLES=1 for the single-cycle RUN case. Each DUT is paired with a
// behavioural 4-bit adder. Inputs change #1 after a rising edge and outputs
// are sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  // NIBBLES=4 instance
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
`ifdef OVERFLOW_FLAG_EN
  logic        out_ovf;
  logic        s1_ovf;
`endif

  // NIBBLES=1 instance
  logic        s1_in_valid;
  logic        s1_in_ready;
  logic [3:0]  s1_in_a;
  logic [3:0]  s1_in_b;
  logic        s1_in_cin;
  logic [3:0]  s1_add_a;
  logic [3:0]  s1_add_b;
  logic        s1_add_cin;
  logic [3:0]  s1_add_sum;
  logic        s1_add_cout;
  logic        s1_out_valid;
  logic        s1_out_ready;
  logic [3:0]  s1_out_sum;
  logic        s1_out_cout;

  int n_cmp;
  int n_err;

  nibble_serial_adder #(.NIBBLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_a      (s1_in_a),
    .in_b      (s1_in_b),
    .in_cin    (s1_in_cin),
    .add_a     (s1_add_a),
    .add_b     (s1_add_b),
    .add_cin   (s1_add_cin),
    .add_sum   (s1_add_sum),
    .add_cout  (s1_add_cout),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready),
    .out_sum   (s1_out_sum),
    .out_cout  (s1_out_cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .out_ovf   (s1_ovf)
`endif
  );

  // External 4-bit ripple adders
  assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign {s1_add_cout, s1_add_sum} = {1'b0, s1_add_a} + {1'b0, s1_add_b} + {4'b0, s1_add_cin};

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = 16'h0;
    in_b         = 16'h0;
    in_cin       = 1'b0;
    out_ready    = 1'b0;
    s1_in_valid  = 1'b0;
    s1_in_a      = 4'h0;
    s1_in_b      = 4'h0;
    s1_in_cin    = 1'b0;
    s1_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Presents one operand pair for one edge (the accept edge T0).
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic c);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Takes the result with a single-edge out_ready pulse.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0) begin n_err++; $display("FAIL reset_out_sum: got %h want 0000", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_err++; $display("FAIL reset_add_drive: got %h/%h/%b want 0/0/0", add_a, add_b, add_cin); end
    n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_s1_in_ready: got %b want 1", s1_in_ready); end
`ifdef OVERFLOW_FLAG_EN
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
`endif
  endtask

  // 0xFFFF + 0x0001: carry ripples through every nibble.
  task automatic test_carry_chain();
    logic [3:0] exp_cin;
    exp_cin = 4'b1110; // nibble k carry-in: 0,1,1,1
    start(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (add_cin !== exp_cin[k]) begin n_err++; $display("FAIL carry_add_cin[%0d]: got %b want %b", k, add_cin, exp_cin[k]); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_early_valid[%0d]: got %b want 0", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL carry_in_ready_run[%0d]: got %b want 0", k, in_ready); end
      tick(1);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL carry_valid_latency: got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== 16'h0000) begin n_err++; $display("FAIL carry_sum: got %h want 0000", out_sum); end
    n_cmp++; if (out_cout !== 1'b1) begin n_err++; $display("FAIL carry_cout: got %b want 1", out_cout); end
    drain();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL carry_drain_ready: got %b want 1", in_ready); end
  endtask

  // 0x1234 + 0x4321 + 1 = 0x5556; nibble order on the adder bus is LSB first.
  task automatic test_values();
    logic [15:0] ea;
    logic [15:0] eb;
    ea = 16'h1234;
    eb = 16'h4321;
    start(16'h1234, 16'h4321, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (add_a !== ea[4*k +: 4]) begin n_err++; $display("FAIL values_add_a[%0d]: got %h want %h", k, add_a, ea[4*k +: 4]); end
      n_cmp++; if (add_b !== eb[4*k +: 4]) begin n_err++; $display("FAIL values_add_b[%0d]: got %h want %h", k, add_b, eb[4*k +: 4]); end
      n_cmp++; if (add_cin !== (k == 0)) begin n_err++; $display("FAIL values_add_cin[%0d]: got %b want %b", k, add_cin, (k == 0)); end
      tick(1);
    end
    n_cmp++; if (out_sum !== 16'h5556) begin n_err++; $display("FAIL values_sum: got %h want 5556", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL values_cout: got %b want 0", out_cout); end
    drain();
  endtask

  // Result held while out_ready is low; adder bus quiet in DONE.
  task automatic test_backpressure();
    start(16'h0F0F, 16'h00F1, 1'b0); // = 0x1000
    tick(4);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (out_sum !== 16'h1000) begin n_err++; $display("FAIL bp_sum[%0d]: got %h want 1000", k, out_sum); end
      n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL bp_cout[%0d]: got %b want 0", k, out_cout); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      n_cmp++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_err++; $display("FAIL bp_add_quiet[%0d]: got %h/%h/%b want 0/0/0", k, add_a, add_b, add_cin); end
      tick(1);
    end
    drain();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
  endtask

  // A second pair held valid through RUN/DONE is ignored until IDLE.
  task automatic test_back_to_back();
    start(16'h1111, 16'h2222, 1'b0); // = 0x3333
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    tick(4);
    n_cmp++; if (out_sum !== 16'h3333) begin n_err++; $display("FAIL b2b_first_sum: got %h want 3333", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL b2b_first_cout: got %b want 0", out_cout); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_done: got %b want 0", in_ready); end
    drain();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_back_idle: got %b want 1", in_ready); end
    tick(1); // second pair accepted here
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got %b want 0", in_ready); end
    n_cmp++; if ({add_a, add_b, add_cin} !== {4'hA, 4'h5, 1'b1}) begin n_err++; $display("FAIL b2b_second_nib0: got %h/%h/%b want a/5/1", add_a, add_b, add_cin); end
    tick(4);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== 16'h0000) begin n_err++; $display("FAIL b2b_second_sum: got %h want 0000", out_sum); end
    n_cmp++; if (out_cout !== 1'b1) begin n_err++; $display("FAIL b2b_second_cout: got %b want 1", out_cout); end
    drain();
  endtask

  // Reset mid-RUN discards the transaction immediately.
  task automatic test_reset_mid_run();
    start(16'h1234, 16'h4321, 1'b1);
    tick(2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({out_sum, out_cout} !== 17'h0) begin n_err++; $display("FAIL rst_mid_out_data: got %h/%b want 0000/0", out_sum, out_cout); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_err++; $display("FAIL rst_mid_add_drive: got %h/%h/%b want 0/0/0", add_a, add_b, add_cin); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_result[%0d]: got %b want 0", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready[%0d]: got %b want 1", k, in_ready); end
    end
  endtask

  // NIBBLES=1: RUN lasts exactly one cycle.
  task automatic test_single_nibble();
    s1_in_a     = 4'hF;
    s1_in_b     = 4'h1;
    s1_in_cin   = 1'b0;
    s1_in_valid = 1'b1;
    tick(1);
    s1_in_valid = 1'b0;
    n_cmp++; if ({s1_add_a, s1_add_b, s1_add_cin} !== {4'hF, 4'h1, 1'b0}) begin n_err++; $display("FAIL s1_run_drive: got %h/%h/%b want f/1/0", s1_add_a, s1_add_b, s1_add_cin); end
    n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL s1_early_valid: got %b want 0", s1_out_valid); end
    tick(1);
    n_cmp++; if (s1_out_valid !== 1'b1) begin n_err++; $display("FAIL s1_valid: got %b want 1", s1_out_valid); end
    n_cmp++; if ({s1_out_sum, s1_out_cout} !== {4'h0, 1'b1}) begin n_err++; $display("FAIL s1_result: got %h/%b want 0/1", s1_out_sum, s1_out_cout); end
    s1_out_ready = 1'b1;
    tick(1);
    s1_out_ready = 1'b0;
    n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL s1_back_idle: got %b want 1", s1_in_ready); end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow();
    start(16'h7FFF, 16'h0001, 1'b0);
    tick(4);
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== {16'h8000, 1'b0, 1'b1}) begin n_err++; $display("FAIL ovf_pos: got %h/%b/%b want 8000/0/1", out_sum, out_cout, out_ovf); end
    drain();
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got %b want 0", out_ovf); end
    start(16'h8000, 16'h8000, 1'b0);
    tick(4);
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== {16'h0000, 1'b1, 1'b1}) begin n_err++; $display("FAIL ovf_neg: got %h/%b/%b want 0000/1/1", out_sum, out_cout, out_ovf); end
    drain();
    start(16'h1234, 16'h4321, 1'b0);
    tick(4);
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== {16'h5555, 1'b0, 1'b0}) begin n_err++; $display("FAIL ovf_none: got %h/%b/%b want 5555/0/0", out_sum, out_cout, out_ovf); end
    drain();
  endtask
`endif

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();
    test_reset();
    test_carry_chain();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_single_nibble();
`ifdef OVERFLOW_FLAG_EN
    test_overflow();
`endif
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
